// File: rtl/snapshot_regbank.sv
// snapshot_regbank: double-buffered byte register bank. A shadow bank is filled from the clk1m write strobe and committed to a live bank read by QSPI bursts.
// Optional define SNAPSHOT_REGBANK_SEQ_EN maps an 8-bit commit counter onto the top address.
module snapshot_regbank #(
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned FRAME_LAST = 11
) (
  input  logic              clk100m,
  input  logic              rst,
  input  logic [7:0]        wr_data,
  input  logic [7:0]        wr_addr,
  input  logic              wr_en,
  input  logic              rd_start,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_next,
  input  logic              rd_end,
  output logic [7:0]        rd_data,
  output logic              rd_busy,
  output logic              frame_valid,
  output logic              overrun,
  input  logic              ovr_clr
);
  localparam int unsigned DEPTH = 1 << ADDR_W;
`ifdef SNAPSHOT_REGBANK_SEQ_EN
  localparam logic [ADDR_W-1:0] TOP = ADDR_W'(DEPTH - 1);
`endif

  typedef enum logic {IDLE, BURST} rd_state_t;
  rd_state_t state, state_next;

  logic              wr_s1, wr_s2, wr_d;
  logic [7:0]        data_s1, addr_s1;
  logic              cap_fire, cap_ok;
  logic [ADDR_W-1:0] cap_idx;
  logic              commit_req, commit_pend, commit_now;
  logic [ADDR_W-1:0] ptr, ptr_next;
  logic [7:0]        shadow [DEPTH];
  logic [7:0]        live   [DEPTH];
  logic [7:0]        rd_byte;
`ifdef SNAPSHOT_REGBANK_SEQ_EN
  logic [7:0]        seq;
`endif

  // Data/address are stable for the whole strobe, so sampling them beside the first sync stage is safe.
  always_ff @(posedge clk100m) begin
    if (rst) begin
      wr_s1   <= 1'b0;
      wr_s2   <= 1'b0;
      wr_d    <= 1'b0;
      data_s1 <= '0;
      addr_s1 <= '0;
    end else begin
      wr_s1   <= wr_en;
      wr_s2   <= wr_s1;
      wr_d    <= wr_s2;
      data_s1 <= wr_data;
      addr_s1 <= wr_addr;
    end
  end

  assign cap_fire = wr_s2 & ~wr_d;
  assign cap_idx  = addr_s1[ADDR_W-1:0];

  always_comb begin
    cap_ok = ((addr_s1 >> ADDR_W) == 8'd0);
`ifdef SNAPSHOT_REGBANK_SEQ_EN
    if (cap_idx == TOP) cap_ok = 1'b0;
`endif
  end

  always_ff @(posedge clk100m) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) shadow[ADDR_W'(i)] <= '0;
      commit_req <= 1'b0;
    end else begin
      commit_req <= 1'b0;
      if (cap_fire && cap_ok) begin
        shadow[cap_idx] <= data_s1;
        commit_req      <= (cap_idx == ADDR_W'(FRAME_LAST));
      end
    end
  end

  // A request raised during a burst parks in commit_pend and fires on the first idle cycle.
  assign commit_now = (commit_req | commit_pend) & (state == IDLE);

  always_ff @(posedge clk100m) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) live[ADDR_W'(i)] <= '0;
      frame_valid <= 1'b0;
      commit_pend <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (commit_now) begin
        for (int unsigned i = 0; i < DEPTH; i++) live[ADDR_W'(i)] <= shadow[ADDR_W'(i)];
        frame_valid <= 1'b1;
        commit_pend <= 1'b0;
      end else if (commit_req) begin
        commit_pend <= 1'b1;
      end
      if (commit_req && commit_pend) overrun <= 1'b1;
      else if (ovr_clr)              overrun <= 1'b0;
    end
  end

`ifdef SNAPSHOT_REGBANK_SEQ_EN
  always_ff @(posedge clk100m) begin
    if (rst)             seq <= '0;
    else if (commit_now) seq <= seq + 8'd1;
  end
`endif

  always_ff @(posedge clk100m) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (rd_start) state_next = BURST;
      BURST: if (!rd_start && rd_end) state_next = IDLE;
    endcase
  end

  always_comb rd_busy = (state == BURST);

  always_comb begin
    ptr_next = ptr;
    if (rd_start)                      ptr_next = rd_addr;
    else if (state == BURST && rd_next) ptr_next = ptr + 1'b1;
  end

  // Read through the commit so a burst opened in the commit cycle already sees the new frame.
  always_comb begin
    rd_byte = commit_now ? shadow[ptr_next] : live[ptr_next];
`ifdef SNAPSHOT_REGBANK_SEQ_EN
    if (ptr_next == TOP) rd_byte = commit_now ? seq + 8'd1 : seq;
`endif
  end

  always_ff @(posedge clk100m) begin
    if (rst) begin
      ptr     <= '0;
      rd_data <= '0;
    end else begin
      ptr     <= ptr_next;
      rd_data <= rd_byte;
    end
  end
endmodule

// File: tb/tb_snapshot_regbank.sv
// Self-checking bench for snapshot_regbank: frame-level reference model plus a read-data scoreboard.
module tb_snapshot_regbank;
  localparam int ADDR_W     = 4;
  localparam int DEPTH      = 16;
  localparam int FRAME_LAST = 11;

  logic              clk100m = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        wr_data = '0;
  logic [7:0]        wr_addr = '0;
  logic              wr_en = 1'b0;
  logic              rd_start = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic              rd_next = 1'b0;
  logic              rd_end = 1'b0;
  logic [7:0]        rd_data;
  logic              rd_busy;
  logic              frame_valid;
  logic              overrun;
  logic              ovr_clr = 1'b0;

  always #5 clk100m = ~clk100m;

  snapshot_regbank #(.ADDR_W(ADDR_W), .FRAME_LAST(FRAME_LAST)) dut (
    .clk100m(clk100m), .rst(rst), .wr_data(wr_data), .wr_addr(wr_addr), .wr_en(wr_en),
    .rd_start(rd_start), .rd_addr(rd_addr), .rd_next(rd_next), .rd_end(rd_end),
    .rd_data(rd_data), .rd_busy(rd_busy), .frame_valid(frame_valid),
    .overrun(overrun), .ovr_clr(ovr_clr)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] sb_q[$];

  // Reference model: whole-frame semantics only.
  logic [7:0] shadow_m[DEPTH];
  logic [7:0] live_m[DEPTH];
  logic [7:0] seq_m;
  bit pend_m, ovr_m, fv_m, open_m;
  int ptr_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_rd(input int a);
`ifdef SNAPSHOT_REGBANK_SEQ_EN
    if (a == DEPTH - 1) return seq_m;
`endif
    return live_m[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      shadow_m[i] = '0;
      live_m[i]   = '0;
    end
    seq_m = '0; pend_m = 0; ovr_m = 0; fv_m = 0; open_m = 0; ptr_m = 0;
  endtask

  task automatic commit_m();
    for (int i = 0; i < DEPTH; i++) live_m[i] = shadow_m[i];
    fv_m  = 1;
    seq_m = seq_m + 8'd1;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk100m);
  endtask

  // Monitor: every accepted read pulse yields one rd_data sample a cycle later.
  always @(posedge clk100m) begin
    if (!rst && (rd_start || (rd_next && open_m))) begin
      #1;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_empty: got rd_data %0h with no expected entry", rd_data);
      end else begin
        check("rd_data", {24'd0, rd_data}, {24'd0, sb_q.pop_front()});
      end
    end
  end

  task automatic do_write(input logic [7:0] a, input logic [7:0] d, input bit clr);
    bit valid, ev;
    wr_addr = a; wr_data = d; wr_en = 1'b1;
    tick(2);
    wr_en = 1'b0;
    tick(1);
    ovr_clr = clr;
    tick(1);
    ovr_clr = 1'b0;
    tick(2);
    valid = (a < DEPTH);
`ifdef SNAPSHOT_REGBANK_SEQ_EN
    if (a == DEPTH - 1) valid = 0;
`endif
    ev = 0;
    if (valid) begin
      shadow_m[a] = d;
      if (a == FRAME_LAST) begin
        if (open_m) begin
          ev = pend_m;
          pend_m = 1;
        end else begin
          commit_m();
        end
      end
    end
    if (ev) ovr_m = 1;
    else if (clr) ovr_m = 0;
  endtask

  task automatic rd_open(input int a, input bit with_end);
    rd_addr = ADDR_W'(a); rd_start = 1'b1; rd_end = with_end;
    ptr_m = a; open_m = 1;
    sb_q.push_back(exp_rd(a));
    tick(1);
    rd_start = 1'b0; rd_end = 1'b0;
  endtask

  task automatic rd_step();
    ptr_m = (ptr_m + 1) % DEPTH;
    sb_q.push_back(exp_rd(ptr_m));
    rd_next = 1'b1;
    tick(1);
    rd_next = 1'b0;
  endtask

  task automatic rd_close();
    rd_end = 1'b1; open_m = 0;
    tick(1);
    rd_end = 1'b0;
    if (pend_m) begin
      commit_m();
      pend_m = 0;
    end
  endtask

  task automatic read_all();
    rd_open(0, 0);
    for (int i = 1; i < DEPTH; i++) rd_step();
    rd_close();
  endtask

  task automatic check_status(input string tag);
    check({tag, "_busy"}, {31'd0, rd_busy}, {31'd0, open_m});
    check({tag, "_fv"}, {31'd0, frame_valid}, {31'd0, fv_m});
    check({tag, "_ovr"}, {31'd0, overrun}, {31'd0, ovr_m});
  endtask

  initial begin
    model_reset();
    tick(3);
    rst = 1'b0;
    check("reset_rd_data", {24'd0, rd_data}, 32'h0);
    check_status("reset");

    rd_open(0, 0);
    check_status("open0");
    rd_close();
    rd_next = 1'b1;
    tick(1);
    rd_next = 1'b0;
    check("idle_next_busy", {31'd0, rd_busy}, 32'd0);

    for (int i = 0; i <= FRAME_LAST; i++) do_write(8'(i), 8'(8'h10 + i), 0);
    check_status("frame1");
    rd_open(0, 0);
    for (int i = 0; i < FRAME_LAST; i++) rd_step();
    rd_close();

    rd_open(0, 0);
    for (int i = 0; i <= FRAME_LAST; i++) do_write(8'(i), 8'(8'hA0 + i), 0);
    for (int i = 0; i < FRAME_LAST; i++) rd_step();
    check_status("held");
    rd_close();
    rd_open(0, 0);
    for (int i = 0; i < FRAME_LAST; i++) rd_step();
    rd_close();

    rd_open(3, 0);
    for (int i = 0; i <= FRAME_LAST; i++) do_write(8'(i), 8'(8'hB0 + i), 0);
    for (int i = 0; i <= FRAME_LAST; i++) do_write(8'(i), 8'(8'hC0 + i), 0);
    rd_step();
    check_status("ovr_set");
    rd_open(5, 1);
    check_status("start_beats_end");
    rd_close();
    read_all();
    ovr_clr = 1'b1; ovr_m = 0;
    tick(1);
    ovr_clr = 1'b0;
    check_status("ovr_clr");

    rd_open(DEPTH - 1, 0);
    rd_step();
    rd_step();
    rd_close();

    do_write(8'(DEPTH - 1), 8'h5A, 0);
    do_write(8'h23, 8'hEE, 0);
    do_write(8'hF0, 8'hEF, 0);
    do_write(8'(FRAME_LAST), 8'h77, 0);
    read_all();

    for (int it = 0; it < 30; it++) begin
      int nw;
      bit op;
      op = ($urandom_range(0, 1) == 1);
      if (op) rd_open($urandom_range(0, DEPTH - 1), 0);
      nw = $urandom_range(1, 14);
      for (int w = 0; w < nw; w++) begin
        logic [7:0] a;
        case ($urandom_range(0, 7))
          0:       a = 8'($urandom_range(DEPTH, 255));
          1, 2:    a = 8'(FRAME_LAST);
          default: a = 8'($urandom_range(0, DEPTH - 1));
        endcase
        do_write(a, 8'($urandom), ($urandom_range(0, 3) == 0));
        if (op) begin
          if ($urandom_range(0, 3) == 0) rd_open($urandom_range(0, DEPTH - 1), $urandom_range(0, 1) == 1);
          else rd_step();
        end
      end
      check_status("rand");
      if (op) rd_close();
      read_all();
    end

    rd_open(2, 0);
    do_write(8'(FRAME_LAST), 8'h99, 0);
    do_write(8'(FRAME_LAST), 8'h9A, 0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    model_reset();
    check("mid_rst_rd_data", {24'd0, rd_data}, 32'h0);
    check_status("mid_rst");
    tick(3);
    check_status("post_rst");
    read_all();

    tick(2);
    check("sb_drained", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
